ins_fetch_queue: RTL and testbench

//   Instruction store and issuer directly upstream of top_control. Host loads a

---
 rtl/INS_CONST.sv | 4 +
 rtl/ins_fetch_queue.sv | 121 ++++++++++++
 tb/tb_ins_fetch_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/INS_CONST.sv
// rtl/INS_CONST.sv - shared instruction constants
package INS_CONST;
    localparam int INST_W = 64;
endpackage

// File: rtl/ins_fetch_queue.sv
// rtl/ins_fetch_queue.sv - instruction RAM and one-at-a-time issuer feeding top_control
module ins_fetch_queue
    import INS_CONST::*;
#(
    parameter int DEPTH       = 256,
    parameter int AW          = 8,
    parameter int DRAIN_GUARD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_wr_en,
    input  logic [AW-1:0]     host_wr_addr,
    input  logic [INST_W-1:0] host_wr_data,
    input  logic              start,
    input  logic [AW:0]       ins_num,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       issued_cnt,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [INST_W-1:0] ins,
    input  logic              working
);

    localparam int DW = $clog2(DRAIN_GUARD + 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [INST_W-1:0] mem [DEPTH];
    logic [AW-1:0]     ptr;
    logic [AW:0]       ins_total;
    logic [AW:0]       ins_num_sat;
    logic [DW-1:0]     drain_cnt;

    // Requests beyond the RAM size saturate, so ptr never needs to wrap.
    assign ins_num_sat = (ins_num > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : ins_num;

    // busy mirrors state != IDLE, so host writes land only between runs.
    always_ff @(posedge clk) begin
        if (host_wr_en && !busy) begin
            mem[host_wr_addr] <= host_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ins_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            issued_cnt <= '0;
            ins        <= '0;
            ptr        <= '0;
            drain_cnt  <= '0;
            ins_total  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        issued_cnt <= '0;
                        ptr        <= '0;
                        busy       <= 1'b1;
                        if (ins_num == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ins_total <= ins_num_sat;
                            state     <= READ;
                        end
                    end
                end
                READ: begin
                    ins       <= mem[ptr];
                    ins_valid <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    // Dropping valid for a cycle after each accept keeps the
                    // downstream idle state from ever seeing a stale word.
                    if (ins_ready) begin
                        ins_valid  <= 1'b0;
                        issued_cnt <= issued_cnt + 1'b1;
                        ptr        <= ptr + 1'b1;
                        if (issued_cnt + 1'b1 == ins_total) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                DRAIN: begin
                    // Array idle must persist long enough to cover its done-flag lag.
                    if (working) begin
                        drain_cnt <= '0;
                    end else if (drain_cnt == DW'(DRAIN_GUARD - 1)) begin
                        drain_cnt <= '0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// tb/tb_ins_fetch_queue.sv - self-checking bench for ins_fetch_queue
module tb_ins_fetch_queue;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              host_wr_en = 1'b0;
    logic [AW-1:0]     host_wr_addr = '0;
    logic [63:0]       host_wr_data = '0;
    logic              start = 1'b0;
    logic [AW:0]       ins_num = '0;
    logic              busy;
    logic              done;
    logic [AW:0]       issued_cnt;
    logic              ins_valid;
    logic              ins_ready = 1'b0;
    logic [63:0]       ins;
    logic              working = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] tb_mem [DEPTH];
    logic [63:0] sb [$];

    typedef struct {
        int n;
        int dly;
        bit bwr;
        bit wws;
        int exp_issued;
    } vec_t;

    vec_t vecs [7];

    ins_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DRAIN_GUARD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .start        (start),
        .ins_num      (ins_num),
        .busy         (busy),
        .done         (done),
        .issued_cnt   (issued_cnt),
        .ins_valid    (ins_valid),
        .ins_ready    (ins_ready),
        .ins          (ins),
        .working      (working)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic host_write(input int addr, input logic [63:0] data);
        host_wr_en   = 1'b1;
        host_wr_addr = AW'(addr);
        host_wr_data = data;
        tb_mem[addr] = data;
        @(negedge clk);
        host_wr_en = 1'b0;
    endtask

    task automatic issue_all(input int n, input int dly, input bit bwr, input bit wws, input int exp_n);
        logic [63:0] w;
        logic [63:0] cur;
        int bad;
        working = 1'b1;
        start   = 1'b1;
        ins_num = (AW+1)'(n);
        if (wws) begin
            w = {$urandom, $urandom};
            host_wr_en   = 1'b1;
            host_wr_addr = '0;
            host_wr_data = w;
            tb_mem[0]    = w;
        end
        for (int i = 0; i < exp_n; i++) sb.push_back(tb_mem[i]);
        @(negedge clk);
        start      = 1'b0;
        host_wr_en = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("valid_in_read", ins_valid, 0);
        for (int k = 0; k < exp_n; k++) begin
            @(negedge clk);
            cur = (sb.size() > 0) ? sb.pop_front() : 64'hx;
            chk("ins_valid_up", ins_valid, 1);
            chk("ins_word", ins, cur);
            chk("cnt_before", issued_cnt, k);
            bad = 0;
            for (int d = 0; d < dly; d++) begin
                if (bwr && k == 0) begin
                    host_wr_en   = 1'b1;
                    host_wr_addr = AW'(1);
                    host_wr_data = ~tb_mem[1];
                end
                @(negedge clk);
                if (ins_valid !== 1'b1 || ins !== cur || issued_cnt !== (AW+1)'(k)) bad++;
            end
            host_wr_en = 1'b0;
            if (dly > 0) chk("hold_stable", bad, 0);
            ins_ready = 1'b1;
            @(negedge clk);
            ins_ready = 1'b0;
            chk("valid_drop", ins_valid, 0);
            chk("cnt_after", issued_cnt, k + 1);
        end
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic drain_check(input bit glitch, input int exp_n);
        @(negedge clk);
        chk("done_while_working", done, 0);
        if (glitch) begin
            working = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("glitch_no_done", done, 0);
            end
            working = 1'b1;
            @(negedge clk);
            chk("glitch_reset", done, 0);
        end
        working = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("drain_early", done, 0);
        end
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_cleared", busy, 0);
        chk("issued_final", issued_cnt, exp_n);
        working = 1'b1;
    endtask

    initial begin
        int bad;
        vecs[0] = '{n: 3,   dly: 2,   bwr: 0, wws: 0, exp_issued: 3};
        vecs[1] = '{n: 2,   dly: 100, bwr: 0, wws: 0, exp_issued: 2};
        vecs[2] = '{n: 3,   dly: 1,   bwr: 1, wws: 0, exp_issued: 3};
        vecs[3] = '{n: 2,   dly: 0,   bwr: 0, wws: 1, exp_issued: 2};
        vecs[4] = '{n: 300, dly: 0,   bwr: 0, wws: 0, exp_issued: 256};
        vecs[5] = '{n: 256, dly: 0,   bwr: 0, wws: 0, exp_issued: 256};
        vecs[6] = '{n: 1,   dly: 3,   bwr: 0, wws: 0, exp_issued: 1};

        repeat (3) @(negedge clk);
        chk("rst_valid", ins_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", issued_cnt, 0);
        chk("rst_ins", ins, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) host_write(i, {$urandom, $urandom});
        host_write(0, 64'hC000_0000_0000_0000);
        host_write(1, 64'h0000_0000_0000_0000);
        host_write(2, 64'h4000_0000_0000_0000);

        for (int v = 0; v < 7; v++) begin
            issue_all(vecs[v].n, vecs[v].dly, vecs[v].bwr, vecs[v].wws, vecs[v].exp_issued);
            drain_check(1'b0, vecs[v].exp_issued);
        end

        // zero-length program goes straight to done
        start   = 1'b1;
        ins_num = '0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_valid", ins_valid, 0);
        chk("zero_cnt", issued_cnt, 0);
        @(negedge clk);
        chk("zero_done_drop", done, 0);
        chk("zero_busy_drop", busy, 0);
        chk("zero_valid2", ins_valid, 0);

        // working blips high in the middle of the drain window
        issue_all(1, 0, 1'b0, 1'b0, 1);
        drain_check(1'b1, 1);

        // reset while the second of five words is on offer
        working = 1'b1;
        start   = 1'b1;
        ins_num = (AW+1)'(5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_run_w0", ins, tb_mem[0]);
        ins_ready = 1'b1;
        @(negedge clk);
        ins_ready = 1'b0;
        @(negedge clk);
        chk("rst_run_valid", ins_valid, 1);
        chk("rst_run_w1", ins, tb_mem[1]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", ins_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", issued_cnt, 0);
        chk("midrst_done", done, 0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0 || ins_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("midrst_quiet", bad, 0);
        issue_all(1, 0, 1'b0, 1'b0, 1);
        drain_check(1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
